io_section_packer: RTL

//  Packs a stream of SECTION_W-bit input sections into ROW_W-bit compressed rows for the

---
 rtl/io_pkg.sv | 10 +
 rtl/io_row_fifo.sv | 41 ++++
 rtl/io_section_packer.sv | 78 +++++++
 3 files changed

// File: rtl/io_pkg.sv
// io_pkg: section-order constants and the slot placement rule shared by the packer and unpacker.
package io_pkg;
    localparam bit ORDER_LSB = 1'b1;
    localparam bit ORDER_MSB = 1'b0;

    // Bit offset of section k inside a row; MSB order fills from the top bits downwards.
    function automatic int slot_offset(input int k, input int sw, input int rw, input bit lsb_first);
        return (lsb_first == ORDER_LSB) ? k * sw : rw - (k + 1) * sw;
    endfunction
endpackage

// File: rtl/io_row_fifo.sv
// io_row_fifo: synchronous show-ahead FIFO with occupancy output; head reads as zero when empty.
module io_row_fifo #(
    parameter  int W     = 20,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_data,
    output logic          o_valid,
    output logic [LW-1:0] o_level
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [LW-1:0] r_level;
    logic          w_pop;

    assign o_valid = r_level != '0;
    assign w_pop   = i_pop & o_valid;
    assign o_data  = o_valid ? r_mem[r_rptr] : '0;
    assign o_level = r_level;

    always_ff @(posedge clk)
        if (i_push) r_mem[r_wptr] <= i_data;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_level <= r_level + LW'(i_push) - LW'(w_pop);
        end
endmodule

// File: rtl/io_section_packer.sv
// io_section_packer: packs SECTION_W-bit sections into ROW_W-bit rows (full or in_last-terminated)
// and buffers the rows in a show-ahead FIFO with valid/ready on both sides.
module io_section_packer
    import io_pkg::*;
#(
    parameter  int SECTION_W  = 4,
    parameter  int ROW_W      = 16,
    parameter  int FIFO_DEPTH = 4,
    parameter  bit LSB_FIRST  = ORDER_LSB,
    localparam int NSEC       = ROW_W / SECTION_W,
    localparam int CW         = $clog2(NSEC + 1),
    localparam int LW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SECTION_W-1:0] in_section,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_W-1:0]     out_row,
    output logic [CW-1:0]        out_nsec,
    output logic                 out_partial,
    output logic [LW-1:0]        fifo_level
);
    localparam logic [CW-1:0] LAST = CW'(NSEC - 1);
    localparam int            FW   = ROW_W + CW + 1;

    if (ROW_W % SECTION_W != 0) begin : g_bad_width
        $error("ROW_W must be a multiple of SECTION_W");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    logic [ROW_W-1:0] r_acc, w_slot;
    logic [CW-1:0]    r_cnt, w_nsec;
    logic             w_accept, w_close;
    logic [FW-1:0]    w_push_data, w_head;

    assign in_ready    = rst & (fifo_level != LW'(FIFO_DEPTH));
    assign w_accept    = in_valid & in_ready;
    assign w_close     = w_accept & (in_last | (r_cnt == LAST));
    assign w_nsec      = r_cnt + 1'b1;
    assign w_push_data = {r_acc | w_slot, w_nsec, w_nsec != CW'(NSEC)};

    always_comb begin
        w_slot = '0;
        for (int k = 0; k < NSEC; k++)
            if (r_cnt == CW'(k)) w_slot[slot_offset(k, SECTION_W, ROW_W, LSB_FIRST) +: SECTION_W] = in_section;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_close) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_acc <= r_acc | w_slot;
            r_cnt <= r_cnt + 1'b1;
        end

    io_row_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_close),
        .i_data  (w_push_data),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_valid (out_valid),
        .o_level (fifo_level)
    );

    assign {out_row, out_nsec, out_partial} = w_head;
endmodule
